// File: rtl/commit_freelist_if.sv
// Handshake bundle between ROB commit/rename and the retirement-side free list.
// The master side (ROB + rename) drives commits and alloc requests; the slave
// side (commit_freelist) returns grants and occupancy.
interface commit_freelist_if #(
  parameter int PHYS_REGS      = 64,
  parameter int DISPATCH_WIDTH = 2
);
  localparam int PREG_W = $clog2(PHYS_REGS);

  logic [DISPATCH_WIDTH-1:0]             commit_en;
  logic [DISPATCH_WIDTH-1:0][4:0]        commit_arch_rd;
  logic [DISPATCH_WIDTH-1:0][PREG_W-1:0] commit_phys_rd;
  logic [DISPATCH_WIDTH-1:0]             alloc_req;
  logic [DISPATCH_WIDTH-1:0][PREG_W-1:0] alloc_phys;
  logic                                  alloc_ready;
  logic [PREG_W:0]                       free_count;

  modport master (
    output commit_en, commit_arch_rd, commit_phys_rd, alloc_req,
    input  alloc_phys, alloc_ready, free_count
  );

  modport slave (
    input  commit_en, commit_arch_rd, commit_phys_rd, alloc_req,
    output alloc_phys, alloc_ready, free_count
  );
endinterface

// File: rtl/commit_freelist.sv
// Retirement-side physical register bookkeeping: committed arch->phys map plus
// a circular free list. Commits push the register each one supersedes; rename
// pops up to DISPATCH_WIDTH registers per cycle. Commit and alloc are fully
// independent within a cycle (no commit->alloc bypass).
module commit_freelist #(
  parameter int PHYS_REGS      = 64,
  parameter int ARCH_REGS      = 32,
  parameter int DISPATCH_WIDTH = 2
) (
  input logic              clk,
  input logic              rst,
  commit_freelist_if.slave bus
);
  localparam int PREG_W    = $clog2(PHYS_REGS);
  localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PREG_W:0]   cnt_t;

  preg_t fl   [PHYS_REGS];
  preg_t cmap [ARCH_REGS];
  preg_t head;
  preg_t tail;
  cnt_t  count;

  logic  alloc_ok;
  preg_t alloc_ofs  [DISPATCH_WIDTH];
  preg_t commit_ofs [DISPATCH_WIDTH];
  preg_t push_val   [DISPATCH_WIDTH];
  preg_t alloc_total;
  preg_t commit_total;

  assign alloc_ok        = (count >= cnt_t'(DISPATCH_WIDTH));
  assign bus.alloc_ready = alloc_ok;
  assign bus.free_count  = count;

  // Packing offsets: each lane's slot is the number of active lanes below it.
  always_comb begin
    // NOTE: running sums inside always_comb use blocking '=' so each loop
    // iteration sees the previous lane's total; every output starts from a
    // default so no latch is inferred.
    alloc_total  = '0;
    commit_total = '0;
    for (int w = 0; w < DISPATCH_WIDTH; w++) begin
      alloc_ofs[w]  = alloc_total;
      commit_ofs[w] = commit_total;
      alloc_total   = alloc_total  + preg_t'(bus.alloc_req[w]);
      commit_total  = commit_total + preg_t'(bus.commit_en[w]);
    end
  end

  // Grants read straight from the registered head; packed even for idle lanes.
  always_comb begin
    for (int w = 0; w < DISPATCH_WIDTH; w++) begin
      bus.alloc_phys[w] = fl[head + alloc_ofs[w]];
    end
  end

  // Register each commit lane releases: the superseded mapping (forwarded from
  // a lower lane that renamed the same arch reg this cycle), or the retiring
  // register itself for x0, which is never remapped.
  always_comb begin
    for (int w = 0; w < DISPATCH_WIDTH; w++) begin
      push_val[w] = cmap[bus.commit_arch_rd[w]];
      for (int v = 0; v < w; v++) begin
        if (bus.commit_en[v] && (bus.commit_arch_rd[v] == bus.commit_arch_rd[w])) begin
          push_val[w] = bus.commit_phys_rd[v];
        end
      end
      if (bus.commit_arch_rd[w] == 5'd0) begin
        push_val[w] = bus.commit_phys_rd[w];
      end
    end
  end

  // Pointers and occupancy; head only moves when the whole group is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= preg_t'(FREE_INIT);
      count <= cnt_t'(FREE_INIT);
    end else begin
      head  <= head + (alloc_ok ? alloc_total : '0);
      tail  <= tail + commit_total;
      count <= count - (alloc_ok ? cnt_t'(alloc_total) : '0) + cnt_t'(commit_total);
    end
  end

  // Free list storage: packed pushes at tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this storage is deliberately reset, because the initial free
      // list contents are architecturally visible through alloc_phys.
      for (int i = 0; i < PHYS_REGS; i++) begin
        fl[i] <= (i < FREE_INIT) ? preg_t'(ARCH_REGS + i) : '0;
      end
    end else begin
      for (int w = 0; w < DISPATCH_WIDTH; w++) begin
        if (bus.commit_en[w]) begin
          fl[tail + commit_ofs[w]] <= push_val[w];
        end
      end
    end
  end

  // Committed map: lanes applied in age order, so the youngest same-reg write wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < ARCH_REGS; a++) begin
        cmap[a] <= preg_t'(a);
      end
    end else begin
      for (int w = 0; w < DISPATCH_WIDTH; w++) begin
        if (bus.commit_en[w] && (bus.commit_arch_rd[w] != 5'd0)) begin
          cmap[bus.commit_arch_rd[w]] <= bus.commit_phys_rd[w];
        end
      end
    end
  end

  // Rename must never request while alloc_ready is low; such requests are dropped.
  a_alloc_legal: assert property (@(posedge clk) disable iff (!rst)
    !((|bus.alloc_req) && !alloc_ok));

  // More free entries than non-architectural registers means a double free upstream.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    count <= cnt_t'(FREE_INIT));

endmodule

// File: tb/tb_commit_freelist.sv
// Self-checking bench for commit_freelist. The reference model is a FIFO of
// free register numbers, a committed-map array, and a pool of allocated but
// not yet committed registers that random commits draw from.
module tb_commit_freelist;
  logic clk;
  logic rst;

  commit_freelist_if #(.PHYS_REGS(64), .DISPATCH_WIDTH(2)) bus ();

  commit_freelist #(.PHYS_REGS(64), .ARCH_REGS(32), .DISPATCH_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  int fq[$];
  int inflight[$];
  int cmap_m[32];

  logic       exp_ready, obs_ready;
  logic [6:0] exp_count, obs_count;
  logic [5:0] exp_g[2], obs_g[2];

  task automatic model_reset();
    fq.delete();
    inflight.delete();
    for (int i = 0; i < 32; i++) fq.push_back(32 + i);
    for (int a = 0; a < 32; a++) cmap_m[a] = a;
  endtask

  task automatic drive_idle();
    bus.alloc_req      = '0;
    bus.commit_en      = '0;
    bus.commit_arch_rd = '0;
    bus.commit_phys_rd = '0;
  endtask

  // One clock cycle, entered and left at a falling edge. Samples the DUT
  // before the rising edge and computes the expected outputs from the model,
  // then advances the model with the same stimulus.
  task automatic cycle(input logic [1:0] req, input logic [1:0] cen,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [5:0] p0, input logic [5:0] p1);
    int k;
    logic [4:0] a[2];
    logic [5:0] p[2];
    a[0] = a0; a[1] = a1; p[0] = p0; p[1] = p1;
    bus.alloc_req         = req;
    bus.commit_en         = cen;
    bus.commit_arch_rd[0] = a0;
    bus.commit_arch_rd[1] = a1;
    bus.commit_phys_rd[0] = p0;
    bus.commit_phys_rd[1] = p1;
    #1;
    obs_ready = bus.alloc_ready;
    obs_count = bus.free_count;
    obs_g[0]  = bus.alloc_phys[0];
    obs_g[1]  = bus.alloc_phys[1];
    exp_ready = (fq.size() >= 2);
    exp_count = 7'(fq.size());
    k = 0;
    for (int w = 0; w < 2; w++) begin
      exp_g[w] = (k < fq.size()) ? 6'(fq[k]) : 6'bx;
      if (req[w]) k++;
    end
    @(posedge clk);
    if (exp_ready) for (int j = 0; j < k; j++) inflight.push_back(fq.pop_front());
    for (int w = 0; w < 2; w++) begin
      if (cen[w]) begin
        for (int j = 0; j < inflight.size(); j++) begin
          if (inflight[j] == int'(p[w])) begin
            inflight.delete(j);
            break;
          end
        end
        if (a[w] != 5'd0) begin
          fq.push_back(cmap_m[a[w]]);
          cmap_m[a[w]] = int'(p[w]);
        end else begin
          fq.push_back(int'(p[w]));
        end
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    bus.alloc_req = 2'b11;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.free_count !== 7'd32) begin n_bad++; $display("FAIL reset free_count: got %0d want 32", bus.free_count); end
    n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset alloc_ready: got %b want 1", bus.alloc_ready); end
    n_cmp++; if (bus.alloc_phys[0] !== 6'd32) begin n_bad++; $display("FAIL reset alloc_phys0: got %0d want 32", bus.alloc_phys[0]); end
    n_cmp++; if (bus.alloc_phys[1] !== 6'd33) begin n_bad++; $display("FAIL reset alloc_phys1: got %0d want 33", bus.alloc_phys[1]); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.free_count !== 7'd32) begin n_bad++; $display("FAIL post-reset free_count: got %0d want 32", bus.free_count); end
    n_cmp++; if (bus.alloc_phys[1] !== 6'd33) begin n_bad++; $display("FAIL post-reset alloc_phys1: got %0d want 33", bus.alloc_phys[1]); end
    drive_idle();
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      cycle(2'b11, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
      n_cmp++; if (obs_g[0] !== 6'(32 + 2 * i) || obs_g[0] !== exp_g[0]) begin n_bad++; $display("FAIL drain grant0 cyc %0d: got %0d want %0d", i, obs_g[0], 32 + 2 * i); end
      n_cmp++; if (obs_g[1] !== 6'(33 + 2 * i) || obs_g[1] !== exp_g[1]) begin n_bad++; $display("FAIL drain grant1 cyc %0d: got %0d want %0d", i, obs_g[1], 33 + 2 * i); end
      n_cmp++; if (obs_count !== exp_count) begin n_bad++; $display("FAIL drain free_count cyc %0d: got %0d want %0d", i, obs_count, exp_count); end
    end
    cycle(2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
    n_cmp++; if (obs_count !== 7'd0) begin n_bad++; $display("FAIL empty free_count: got %0d want 0", obs_count); end
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL empty alloc_ready: got %b want 0", obs_ready); end
  endtask

  task automatic test_refill();
    cycle(2'b00, 2'b01, 5'd5, 5'd0, 6'd40, 6'd0);
    cycle(2'b00, 2'b01, 5'd7, 5'd0, 6'd41, 6'd0);
    n_cmp++; if (obs_count !== 7'd1) begin n_bad++; $display("FAIL refill free_count after one: got %0d want 1", obs_count); end
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL refill alloc_ready after one: got %b want 0", obs_ready); end
    cycle(2'b11, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
    n_cmp++; if (obs_count !== 7'd2 || obs_ready !== 1'b1) begin n_bad++; $display("FAIL refill count/ready: got %0d/%b want 2/1", obs_count, obs_ready); end
    n_cmp++; if (obs_g[0] !== 6'd5 || obs_g[0] !== exp_g[0]) begin n_bad++; $display("FAIL refill grant0: got %0d want 5", obs_g[0]); end
    n_cmp++; if (obs_g[1] !== 6'd7 || obs_g[1] !== exp_g[1]) begin n_bad++; $display("FAIL refill grant1: got %0d want 7", obs_g[1]); end
  endtask

  task automatic test_lane_gap();
    cycle(2'b00, 2'b11, 5'd10, 5'd11, 6'd42, 6'd43);
    cycle(2'b10, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
    n_cmp++; if (obs_g[1] !== 6'd10 || obs_g[1] !== exp_g[1]) begin n_bad++; $display("FAIL gap grant1: got %0d want 10", obs_g[1]); end
    cycle(2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
    n_cmp++; if (obs_count !== 7'd1 || obs_count !== exp_count) begin n_bad++; $display("FAIL gap free_count: got %0d want 1", obs_count); end
  endtask

  task automatic test_collision();
    cycle(2'b00, 2'b11, 5'd9, 5'd9, 6'd50, 6'd51);
    cycle(2'b11, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
    n_cmp++; if (obs_count !== 7'd3 || obs_count !== exp_count) begin n_bad++; $display("FAIL collision free_count: got %0d want 3", obs_count); end
    n_cmp++; if (obs_g[0] !== 6'd11 || obs_g[1] !== 6'd9) begin n_bad++; $display("FAIL collision grants: got %0d/%0d want 11/9", obs_g[0], obs_g[1]); end
    cycle(2'b00, 2'b01, 5'd12, 5'd0, 6'd44, 6'd0);
    cycle(2'b11, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
    n_cmp++; if (obs_g[0] !== 6'd50 || obs_g[1] !== 6'd12) begin n_bad++; $display("FAIL collision second grants: got %0d/%0d want 50/12", obs_g[0], obs_g[1]); end
    // Re-commit x9 and x5: the released registers expose cmap[9]=51 and cmap[5]=40.
    cycle(2'b00, 2'b11, 5'd9, 5'd5, 6'd46, 6'd47);
    cycle(2'b11, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
    n_cmp++; if (obs_g[0] !== 6'd51 || obs_g[1] !== 6'd40) begin n_bad++; $display("FAIL cmap readback grants: got %0d/%0d want 51/40", obs_g[0], obs_g[1]); end
  endtask

  task automatic test_x0();
    cycle(2'b00, 2'b01, 5'd0, 5'd0, 6'd45, 6'd0);
    cycle(2'b00, 2'b10, 5'd0, 5'd0, 6'd0, 6'd48);
    cycle(2'b11, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
    n_cmp++; if (obs_g[0] !== 6'd45 || obs_g[1] !== 6'd48) begin n_bad++; $display("FAIL x0 grants: got %0d/%0d want 45/48", obs_g[0], obs_g[1]); end
  endtask

  task automatic test_random();
    logic [1:0] req, cen;
    logic [4:0] a[2];
    logic [5:0] p[2];
    int idx;
    for (int i = 0; i < 400; i++) begin
      req = (fq.size() >= 2) ? 2'($urandom_range(0, 3)) : 2'b00;
      cen = '0;
      for (int w = 0; w < 2; w++) begin
        a[w] = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        p[w] = '0;
        if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
          idx    = $urandom_range(0, inflight.size() - 1);
          p[w]   = 6'(inflight[idx]);
          inflight.delete(idx);
          cen[w] = 1'b1;
        end
      end
      cycle(req, cen, a[0], a[1], p[0], p[1]);
      n_cmp++; if (obs_count !== exp_count) begin n_bad++; $display("FAIL random free_count cyc %0d: got %0d want %0d", i, obs_count, exp_count); end
      n_cmp++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL random alloc_ready cyc %0d: got %b want %b", i, obs_ready, exp_ready); end
      for (int w = 0; w < 2; w++) begin
        if (req[w]) begin
          n_cmp++; if (obs_g[w] !== exp_g[w]) begin n_bad++; $display("FAIL random grant%0d cyc %0d: got %0d want %0d", w, i, obs_g[w], exp_g[w]); end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    // Reach a partially drained state, then pulse reset between clock edges.
    for (int i = 0; i < 3; i++) begin
      if (fq.size() >= 2) cycle(2'b11, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.free_count !== 7'd32) begin n_bad++; $display("FAIL mid-reset free_count: got %0d want 32", bus.free_count); end
    n_cmp++; if (bus.alloc_phys[0] !== 6'd32) begin n_bad++; $display("FAIL mid-reset alloc_phys0: got %0d want 32", bus.alloc_phys[0]); end
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cycle(2'b11, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0);
      n_cmp++; if (obs_g[0] !== 6'(32 + 2 * i) || obs_g[1] !== 6'(33 + 2 * i)) begin n_bad++; $display("FAIL restart grants cyc %0d: got %0d/%0d want %0d/%0d", i, obs_g[0], obs_g[1], 32 + 2 * i, 33 + 2 * i); end
      n_cmp++; if (obs_count !== exp_count) begin n_bad++; $display("FAIL restart free_count cyc %0d: got %0d want %0d", i, obs_count, exp_count); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    drive_idle();
    model_reset();
    test_reset();
    test_drain();
    test_refill();
    test_lane_gap();
    test_collision();
    test_x0();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/commit_freelist.md
# commit_freelist

Retirement-side physical register bookkeeping, downstream of the ROB commit port and upstream of rename. Holds the committed architectural→physical map and a circular free list of physical registers. Each cycle it accepts up to DISPATCH_WIDTH commits, releasing the physical register each one supersedes. It also hands up to DISPATCH_WIDTH free physical registers per cycle to rename.

## Interface
- PHYS_REGS, 64: physical register count, power of two. PREG_W = log2(PHYS_REGS).
- ARCH_REGS, 32: architectural register count, fixed at 32.
- DISPATCH_WIDTH, 2: lanes per cycle for both alloc and commit. Lane 0 is the oldest.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. Asynchronous, active-low: rst=0 resets immediately.
- commit_en  in  [DISPATCH_WIDTH]  lane commits this cycle. Asserted for exactly one cycle per committed instruction.
- commit_arch_rd  in  [DISPATCH_WIDTH][5]  architectural destination.
- commit_phys_rd  in  [DISPATCH_WIDTH][PREG_W]  physical destination being retired.
- alloc_req  in  [DISPATCH_WIDTH]  rename consumes a free register on this lane.
- alloc_phys  out  [DISPATCH_WIDTH][PREG_W]  register granted to each requesting lane. Combinational.
- alloc_ready  out  1  at least DISPATCH_WIDTH registers are free.
- free_count  out  PREG_W+1  registered count of free entries.

## Operation
- Free list is a circular buffer fl[PHYS_REGS] with head (pop), tail (push) and count.
  - head and tail are PREG_W bits wide and wrap modulo PHYS_REGS.
  - count is PREG_W+1 bits wide.
- Committed map cmap[32] holds PREG_W-bit entries.
- Reset state:
  - cmap[a]=a.
  - fl[i]=ARCH_REGS+i for i<PHYS_REGS-ARCH_REGS; all other fl entries are 0.
  - head=0; tail=PHYS_REGS-ARCH_REGS (mod PHYS_REGS); count=PHYS_REGS-ARCH_REGS.
- Alloc:
  - Lane w is granted fl[head + popcount(alloc_req[w-1:0])]. Requesting lanes are packed, so a gap in lane 0 gives lane 1 fl[head].
  - alloc_phys for a non-requesting lane is don't-care; drive the packed value anyway.
  - On the edge, head += popcount(alloc_req).
  - alloc_ready = (count >= DISPATCH_WIDTH). It is all-or-nothing: rename never splits a group.
  - Asserting alloc_req while alloc_ready=0 is illegal. The block ignores it (head unchanged) and fires an assertion.
- Commit, per lane in order 0..DISPATCH_WIDTH-1, when commit_en[w]=1:
  - arch_rd≠0:
    - old = current mapping of arch_rd, including any lower-lane commit this cycle to the same arch_rd.
    - Push old; then cmap[arch_rd] ← phys_rd.
  - arch_rd=0: push phys_rd itself; cmap unchanged.
  - Pushes are packed: lane w writes fl[tail + popcount(commit_en[w-1:0])]. tail += popcount(commit_en).
- Same-arch collision (both lanes commit the same arch_rd≠0):
  - lane 0 frees the old cmap entry;
  - lane 1 frees lane 0's phys_rd;
  - cmap ends at lane 1's phys_rd.
- Count update: count ← count − popcount(alloc_req·alloc_ready) + popcount(commit_en).
- Overflow (count > PHYS_REGS−ARCH_REGS) is impossible under correct upstream behaviour and is checked by an assertion.

## Timing
- alloc_phys and alloc_ready are valid in the same cycle from registered head/count. The grant is consumed at the next edge.
- A register freed by a commit at edge N is allocatable in cycle N+1 at the earliest. There is no same-cycle bypass from commit to alloc.
- Simultaneous alloc and commit in one cycle are independent: head and tail move separately and count applies the net change.
- Wrap-around: head and tail wrap silently. fl is indexed modulo PHYS_REGS and never overruns, because count ≤ PHYS_REGS−ARCH_REGS < PHYS_REGS.
- Reset asserted mid-operation restores the full reset state asynchronously. The first edge after rst deasserts behaves as if from a fresh reset.
- Outputs during and immediately after reset: alloc_phys[0]=32, alloc_phys[1]=33, alloc_ready=1, free_count=32.

## Test plan
- Reset then alloc_req=2'b11 for 16 cycles.
  - Grants 32/33, 34/35, …, 62/63.
  - free_count then 0; alloc_ready=0.
- With the list empty, commit (x5, p40) on lane 0.
  - Next cycle free_count=1, fl holds p5, cmap[5]=40.
  - Another (x7, p41) commit brings count to 2, alloc_ready=1, and grants p5 then p7.
- alloc_req=2'b10 only → lane 1 gets fl[head], head advances by 1.
- Both lanes commit x9, lane 0 p50 and lane 1 p51 → p9 and p50 freed in that order, cmap[9]=51, count +2.
- Commit (x0, p45) → p45 pushed, cmap[0] stays 0.
- Mid-stream (count=3, head=20), pull rst low for a partial cycle.
  - Immediately: free_count=32, alloc_phys[0]=32.
  - After release the allocation sequence restarts at 32.
